washer_phase_timer: RTL and testbench

Phase duration timer and sequencer for the washing-machine controller. Watches the controller's one-hot phase outputs, loads a per-phase duration, and counts it down on a prescaled tick. Raises the matching expiry flag for the controller's timer inputs. Also supports pausing the count and reports remaining time for the display block.

---
 rtl/washer_phase_timer.sv | 162 ++++++++++++++++
 tb/tb_washer_phase_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/washer_phase_timer.sv
// Phase duration timer for the washer controller: loads a per-phase tick count on a
// one-hot phase change, counts it down on a prescaled tick and raises the expiry flag.
// Optional extend input enabled by defining WASHER_TIMER_EXTEND_EN.
module washer_phase_timer #(
  parameter int CNT_W     = 16,
  parameter int PRE_W     = 16,
  parameter int PRESCALE  = 1000,
  parameter int T_SOAK_LO = 100,
  parameter int T_SOAK_HI = 200,
  parameter int T_WASH_LO = 300,
  parameter int T_WASH_HI = 500,
  parameter int T_DRAIN   = 50,
  parameter int T_RINSE   = 150,
  parameter int T_SPIN    = 120,
  parameter int EXT_TICKS = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       phase_in,
  input  logic             pause,
`ifdef WASHER_TIMER_EXTEND_EN
  input  logic             extend,
`endif
  output logic [6:0]       timer_out,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t           state_q;
  logic [6:0]       phase_q;
  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       tout_q;
  logic             err_q;

  // Results of one counting step, shared by RUN and by leaving PAUSED.
  logic             tick_d;
  logic [CNT_W-1:0] cnt_run_d;
  logic [PRE_W-1:0] pre_run_d;
  logic             expire_run_d;
  logic [CNT_W-1:0] cnt_hold_d;

  // Tick count loaded for each phase; anything not one-hot loads zero.
  function automatic logic [CNT_W-1:0] dur(input logic [6:0] p);
    case (p)
      7'h01:   dur = CNT_W'(T_SOAK_LO);
      7'h02:   dur = CNT_W'(T_SOAK_HI);
      7'h04:   dur = CNT_W'(T_WASH_LO);
      7'h08:   dur = CNT_W'(T_WASH_HI);
      7'h10:   dur = CNT_W'(T_DRAIN);
      7'h20:   dur = CNT_W'(T_RINSE);
      7'h40:   dur = CNT_W'(T_SPIN);
      default: dur = '0;
    endcase
  endfunction

`ifdef WASHER_TIMER_EXTEND_EN
  // Add the extension amount, clamping at the counter's all-ones value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(EXT_TICKS);
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
`endif

  // Next counter/prescaler values for a counting cycle and for a held (paused) cycle.
  always_comb begin
    tick_d    = (pre_q == PRE_W'(PRESCALE - 1));
    cnt_run_d = tick_d ? (cnt_q - 1'b1) : cnt_q;
    pre_run_d = tick_d ? '0 : (pre_q + 1'b1);
    cnt_hold_d = cnt_q;
`ifdef WASHER_TIMER_EXTEND_EN
    if (extend) begin
      cnt_run_d  = sat_add(cnt_run_d);
      cnt_hold_d = sat_add(cnt_q);
    end
`endif
    // An extend landing on the final decrement keeps the phase alive.
    expire_run_d = tick_d && (cnt_run_d == '0);
  end

  // Sequencer: phase-change handling first, then per-state counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= '0;
      err_q   <= 1'b0;
    end else if (phase_in != phase_q) begin
      tout_q <= '0;
      if (phase_in == 7'h00) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        phase_q <= '0;
      end else if (!$onehot(phase_in)) begin
        // Illegal encoding: park idle and flag it; the last good phase is kept.
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end else begin
        state_q <= S_LOAD;
        phase_q <= phase_in;
        err_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        S_LOAD: begin
          cnt_q <= dur(phase_q);
          pre_q <= '0;
          if (dur(phase_q) == '0) begin
            state_q <= S_EXPIRED;
            tout_q  <= phase_q;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN, S_PAUSED: begin
          if (pause) begin
            state_q <= S_PAUSED;
            cnt_q   <= cnt_hold_d;
          end else begin
            // Leaving PAUSED counts on the same edge, so each paused cycle costs one cycle.
            pre_q <= pre_run_d;
            cnt_q <= cnt_run_d;
            if (expire_run_d) begin
              state_q <= S_EXPIRED;
              tout_q  <= phase_q;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_EXPIRED: begin
          state_q <= S_EXPIRED;
        end
        default: begin
          state_q <= S_IDLE;
          tout_q  <= '0;
        end
      endcase
    end
  end

  assign timer_out = tout_q;
  assign remaining = cnt_q;
  assign phase_err = err_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule

// File: tb/tb_washer_phase_timer.sv
// Scoreboard bench for washer_phase_timer: expected expiry events are queued when a
// phase is driven and matched when timer_out rises; point checks cover the rest.
// Extend tests are included when WASHER_TIMER_EXTEND_EN is defined.
module tb_washer_phase_timer;

  localparam int P   = 4;
  localparam int TD  = 3;
  localparam int TWL = 4;
  localparam int TR  = 5;
  localparam int TS  = 9;
`ifdef WASHER_TIMER_EXTEND_EN
  localparam int CW  = 8;
`else
  localparam int CW  = 16;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    phase_in = 7'h00;
  logic          pause = 1'b0;
`ifdef WASHER_TIMER_EXTEND_EN
  logic          extend = 1'b0;
`endif
  logic [6:0]    timer_out;
  logic          busy;
  logic [CW-1:0] remaining;
  logic          phase_err;

  washer_phase_timer #(
    .CNT_W(CW), .PRE_W(16), .PRESCALE(P),
    .T_SOAK_LO(2), .T_SOAK_HI(2), .T_WASH_LO(TWL), .T_WASH_HI(3),
    .T_DRAIN(TD), .T_RINSE(TR), .T_SPIN(TS), .EXT_TICKS(60)
  ) dut (
    .clk(clk),
    .rst(rst),
    .phase_in(phase_in),
    .pause(pause),
`ifdef WASHER_TIMER_EXTEND_EN
    .extend(extend),
`endif
    .timer_out(timer_out),
    .busy(busy),
    .remaining(remaining),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] tout;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Match every rising expiry flag against the oldest queued expectation.
  logic [6:0] prev_tout = 7'h00;
  always @(negedge clk) begin
    if (timer_out !== prev_tout && timer_out !== 7'h00) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {25'd0, timer_out}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_tout", {25'd0, timer_out}, {25'd0, mon_e.tout});
        check("sb_cycle", cyc, mon_e.cyc);
      end
    end
    prev_tout = timer_out;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive a phase at a negedge; its change is sampled on the next edge (edge N).
  task automatic start(input logic [6:0] ph, input int t, input bit push, output int c);
    phase_in = ph;
    c = cyc;
    if (push) sb.push_back('{c + 2 + t * P, ph});
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int c;
    int r;
    // Reset state
    rst = 1'b1;
    tick_n(3);
    check("rst_tout", {25'd0, timer_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    check("rst_err", {31'd0, phase_err}, 32'd0);
    rst = 1'b0;
    tick_n(1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Plain drain countdown
    start(7'h10, TD, 1'b1, c);
    tick_n(1);
    check("drain_load_busy", {31'd0, busy}, 32'd1);
    tick_n(1);
    check("drain_load_rem", 32'(remaining), TD);
    wait_to(c + 2 + TD * P - 1);
    check("drain_pre_tout", {25'd0, timer_out}, 32'd0);
    wait_to(c + 2 + TD * P);
    check("drain_tout", {25'd0, timer_out}, 32'h10);
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_rem", 32'(remaining), 32'd0);

    // Drain with five paused cycles
    phase_in = 7'h00;
    tick_n(1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_tout", {25'd0, timer_out}, 32'd0);
    start(7'h10, TD, 1'b0, c);
    sb.push_back('{c + 2 + TD * P + 5, 7'h10});
    wait_to(c + 4);
    pause = 1'b1;
    tick_n(1);
    check("pause_busy", {31'd0, busy}, 32'd1);
    tick_n(2);
    check("pause_rem_a", 32'(remaining), TD);
    tick_n(2);
    check("pause_rem_b", 32'(remaining), TD);
    pause = 1'b0;
    wait_to(c + 2 + TD * P + 4);
    check("pause_pre_tout", {25'd0, timer_out}, 32'd0);
    wait_to(c + 2 + TD * P + 5);
    check("pause_tout", {25'd0, timer_out}, 32'h10);

    // Expired wash_low then switch to drain
    start(7'h04, TWL, 1'b1, c);
    wait_to(c + 2 + TWL * P);
    check("wash_tout", {25'd0, timer_out}, 32'h04);
    start(7'h10, TD, 1'b1, c);
    tick_n(1);
    check("switch_tout", {25'd0, timer_out}, 32'd0);
    check("switch_busy", {31'd0, busy}, 32'd1);
    tick_n(1);
    check("switch_rem", 32'(remaining), TD);
    wait_to(c + 2 + TD * P);
    check("switch_drain_tout", {25'd0, timer_out}, 32'h10);

    // Illegal phase encoding, then rinse
    phase_in = 7'h30;
    tick_n(1);
    check("err_flag", {31'd0, phase_err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_tout", {25'd0, timer_out}, 32'd0);
    tick_n(1);
    check("err_hold", {31'd0, phase_err}, 32'd1);
    start(7'h20, TR, 1'b1, c);
    tick_n(1);
    check("rinse_err", {31'd0, phase_err}, 32'd0);
    check("rinse_busy", {31'd0, busy}, 32'd1);
    tick_n(1);
    check("rinse_rem", 32'(remaining), TR);
    wait_to(c + 2 + TR * P);
    check("rinse_tout", {25'd0, timer_out}, 32'h20);

    // Reset mid-run, then full spin reload
    start(7'h40, TS, 1'b0, c);
    wait_to(c + 11);
    check("spin_rem7", 32'(remaining), TS - 2);
    rst = 1'b1;
    tick_n(1);
    check("mid_rst_tout", {25'd0, timer_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rem", 32'(remaining), 32'd0);
    check("mid_rst_err", {31'd0, phase_err}, 32'd0);
    tick_n(1);
    rst = 1'b0;
    start(7'h40, TS, 1'b1, c);
    tick_n(1);
    check("spin_busy", {31'd0, busy}, 32'd1);
    tick_n(1);
    check("spin_rem", 32'(remaining), TS);
    wait_to(c + 2 + TS * P);
    check("spin_tout", {25'd0, timer_out}, 32'h40);

`ifdef WASHER_TIMER_EXTEND_EN
    // Extend while paused, saturating at the counter maximum
    start(7'h20, TR, 1'b0, c);
    wait_to(c + 2);
    pause = 1'b1;
    tick_n(2);
    r = TR;
    for (int i = 0; i < 5; i++) begin
      extend = 1'b1;
      tick_n(1);
      extend = 1'b0;
      r = (r + 60 > 255) ? 255 : r + 60;
      check("ext_rem", 32'(remaining), r);
    end
    pause = 1'b0;
    phase_in = 7'h00;
    tick_n(1);
    // Extend ignored once expired
    start(7'h10, TD, 1'b1, c);
    wait_to(c + 2 + TD * P);
    extend = 1'b1;
    tick_n(1);
    extend = 1'b0;
    check("ext_expired_rem", 32'(remaining), 32'd0);
    check("ext_expired_tout", {25'd0, timer_out}, 32'h10);
`endif

    tick_n(2);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
